// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// parameter legality check.
package serial_adder_pkg;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell; the serial adder reuses one instance every cycle.
module fa_cell (
  output logic s,
  output logic r_out,
  input  logic a,
  input  logic b,
  input  logic r_in
);

  assign s     = a ^ b ^ r_in;
  assign r_out = (a & b) | (r_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes: {r_out,s} = a + b + r_in,
// computed LSB first over WIDTH cycles through one full-adder cell.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             r_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             r_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_width_check
      $error("serial_adder_ctrl: WIDTH out of range 1..32");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .s     (fa_s),
    .r_out (fa_c),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .r_in  (carry)
  );

  // Shift-in at the MSB written without a part-select so WIDTH=1 elaborates.
  always_comb begin
    s_next            = s_sh >> 1;
    s_next[WIDTH-1]   = fa_s;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      r_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= r_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            s         <= s_next;
            r_out     <= fa_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
